// File: rtl/fifo_pkg.sv
// Shared types and sizing helpers for the 16-entry FIFO occupancy controller.
package fifo_pkg;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } fifo_state_t;

    localparam int FIFO_DEPTH = 16;

    // Occupancy must represent 0..depth inclusive, hence depth+1 codes.
    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Occupancy, full/empty state and sticky error flags for the FIFO; qualifies
// raw requests into enables for the write/read address counters.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH    = FIFO_DEPTH,
    parameter int CNT_W    = cnt_width(DEPTH),
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_req,
    input  logic             rd_req,
    output logic             wr_en,
    output logic             rd_en,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [CNT_W-1:0] DEPTH_M1 = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] AF_C     = CNT_W'(AF_LEVEL);
    localparam logic [CNT_W-1:0] AE_C     = CNT_W'(AE_LEVEL);

    fifo_state_t      state_q;
    fifo_state_t      state_d;
    logic [CNT_W-1:0] count_d;

    assign full  = (state_q == S_FULL);
    assign empty = (state_q == S_EMPTY);

    // A write is refused when full even if a read is accepted alongside it,
    // so the write pointer can never lap the read pointer.
    assign wr_en = rst & wr_req & ~full;
    assign rd_en = rst & rd_req & ~empty;

    always_comb begin
        count_d = count;
        case ({wr_en, rd_en})
            2'b10:   count_d = count + ONE;
            2'b01:   count_d = count - ONE;
            default: count_d = count;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: if (wr_en) state_d = S_PART;
            S_PART: begin
                if (count == DEPTH_M1 && wr_en && !rd_en)
                    state_d = S_FULL;
                else if (count == ONE && rd_en && !wr_en)
                    state_d = S_EMPTY;
            end
            S_FULL:  if (rd_en) state_d = S_PART;
            default: state_d = S_EMPTY;
        endcase
    end

    // Almost flags come from the next count so they move together with count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_EMPTY;
            count        <= '0;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            state_q      <= state_d;
            count        <= count_d;
            almost_full  <= (count_d >= AF_C);
            almost_empty <= (count_d <= AE_C);
            overflow     <= overflow | (wr_req & full);
            underflow    <= underflow | (rd_req & empty);
        end
    end

endmodule

// File: tb/tb_fifo_ctrl.sv
// Directed self-checking bench for fifo_ctrl: fill/drain, simultaneous
// requests at each occupancy boundary, sticky errors and asynchronous reset.
module tb_fifo_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       wr_req = 1'b0;
    logic       rd_req = 1'b0;
    logic       wr_en, rd_en;
    logic [4:0] count;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;

    int check_count = 0;
    int pass_count  = 0;

    fifo_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .wr_req       (wr_req),
        .rd_req       (rd_req),
        .wr_en        (wr_en),
        .rd_en        (rd_en),
        .count        (count),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    // Occupancy must saturate at 16 and never wrap below zero.
    always @(negedge clk) begin
        if (rst) begin
            check_count++;
            assert (count <= 5'd16) pass_count++;
            else $error("[TB] FAIL saturation: count=%0d required<=16", count);
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
    endtask

    task automatic checkState(input string tag, input int cnt, input logic f,
                              input logic e, input logic af, input logic ae,
                              input logic ovf, input logic udf);
        checkOutput({tag, ".count"}, 32'(count), cnt);
        checkOutput({tag, ".full"}, 32'(full), 32'(f));
        checkOutput({tag, ".empty"}, 32'(empty), 32'(e));
        checkOutput({tag, ".almost_full"}, 32'(almost_full), 32'(af));
        checkOutput({tag, ".almost_empty"}, 32'(almost_empty), 32'(ae));
        checkOutput({tag, ".overflow"}, 32'(overflow), 32'(ovf));
        checkOutput({tag, ".underflow"}, 32'(underflow), 32'(udf));
    endtask

    // Drives one cycle of requests, checks the qualified enables mid-cycle,
    // then returns 1 time unit after the closing edge.
    task automatic applyStimulus(input string tag, input logic wr, input logic rd,
                                 input logic exp_wr_en, input logic exp_rd_en);
        wr_req = wr;
        rd_req = rd;
        #1;
        checkOutput({tag, ".wr_en"}, 32'(wr_en), 32'(exp_wr_en));
        checkOutput({tag, ".rd_en"}, 32'(rd_en), 32'(exp_rd_en));
        @(posedge clk);
        #1;
        wr_req = 1'b0;
        rd_req = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b0;
        #3;
        rst = 1'b1;
    endtask

    initial begin
        // Enables stay low while reset is held, whatever is requested.
        #2;
        wr_req = 1'b1;
        rd_req = 1'b1;
        #1;
        checkOutput("in_reset.wr_en", 32'(wr_en), 32'd0);
        checkOutput("in_reset.rd_en", 32'(rd_en), 32'd0);
        wr_req = 1'b0;
        rd_req = 1'b0;
        #9;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkState("idle", 0, 0, 1, 0, 1, 0, 0);
        checkOutput("idle.wr_en", 32'(wr_en), 32'd0);
        checkOutput("idle.rd_en", 32'(rd_en), 32'd0);

        // Fill
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("fill", 1, 0, 1, 0);
            checkState("fill", i, (i == 16), 0, (i >= 14), (i <= 2), 0, 0);
        end
        applyStimulus("fill17", 1, 0, 0, 0);
        checkState("fill17", 16, 1, 0, 1, 0, 1, 0);

        // Drain
        for (int i = 1; i <= 16; i++) begin
            applyStimulus("drain", 0, 1, 0, 1);
            checkState("drain", 16 - i, 0, (i == 16), (16 - i >= 14), (16 - i <= 2), 1, 0);
        end
        applyStimulus("drain17", 0, 1, 0, 0);
        checkState("drain17", 0, 0, 1, 0, 1, 1, 1);

        // Simultaneous requests at count 8, then at full
        pulseReset();
        #1;
        checkState("rst2", 0, 0, 1, 0, 1, 0, 0);
        for (int i = 0; i < 8; i++) applyStimulus("to8", 1, 0, 1, 0);
        checkState("at8", 8, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            applyStimulus("both8", 1, 1, 1, 1);
            checkOutput("both8.count", 32'(count), 32'd8);
        end
        for (int i = 0; i < 8; i++) applyStimulus("to16", 1, 0, 1, 0);
        checkState("at16", 16, 1, 0, 1, 0, 0, 0);
        applyStimulus("both16", 1, 1, 0, 1);
        checkState("both16", 15, 0, 0, 1, 0, 1, 0);

        // Simultaneous requests when empty
        @(posedge clk);
        #1;
        pulseReset();
        #1;
        applyStimulus("both0", 1, 1, 1, 0);
        checkState("both0", 1, 0, 0, 0, 1, 0, 1);

        // Asynchronous reset mid-operation at count 10 with overflow set
        pulseReset();
        #1;
        for (int i = 0; i < 16; i++) applyStimulus("refill", 1, 0, 1, 0);
        applyStimulus("ovf", 1, 0, 0, 0);
        for (int i = 0; i < 6; i++) applyStimulus("to10", 0, 1, 0, 1);
        checkState("at10", 10, 0, 0, 0, 0, 1, 0);
        rst = 1'b0;
        #2;
        checkState("async_rst", 0, 0, 1, 0, 1, 0, 0);
        wr_req = 1'b1;
        #1;
        checkOutput("async_rst.wr_en", 32'(wr_en), 32'd0);
        wr_req = 1'b0;
        rst = 1'b1;
        applyStimulus("post_rst", 1, 0, 1, 0);
        checkState("post_rst", 1, 0, 0, 0, 1, 0, 0);

        $display("[TB] %0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
